// File: rtl/spread_pkg.sv
// Shared types and constants for the direct-sequence spreader.
package spread_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_IDLE   = 2'd1,
        S_SPREAD = 2'd2
    } state_t;

    localparam logic MODE_SHORT = 1'b0;
    localparam logic MODE_LONG  = 1'b1;

    // Counter width for a range 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spread_ch_lfsr_gen.sv
// Fibonacci shift-right LFSR; restart reloads the seed ahead of any advance.
module lfsr_gen #(
    parameter int unsigned           LFSR_W = 7,
    parameter logic [LFSR_W-1:0]     POLY   = 7'h03,
    parameter logic [LFSR_W-1:0]     SEED   = 7'h01
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_en,
    output logic o_data
);

    logic [LFSR_W-1:0] state;
    logic              fb;

    assign fb     = ^(state & POLY);
    assign o_data = state[0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= SEED;
        end else if (i_restart) begin
            state <= SEED;
        end else if (i_en) begin
            state <= {fb, state[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/spread_ch.sv
// Direct-sequence spreader: each data bit LSB-first becomes SPREAD chips of a
// short code captured from the LFSR, or of the free-running LFSR long code.
module spread_ch
    import spread_pkg::*;
#(
    parameter int unsigned       SPREAD = 24,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 7,
    parameter logic [LFSR_W-1:0] POLY   = 7'h03,
    parameter logic [LFSR_W-1:0] SEED   = 7'h01
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_restart,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last
);

    localparam int unsigned       CHIP_W    = cnt_w(SPREAD);
    localparam int unsigned       BIT_W     = cnt_w(DATA_W);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(SPREAD - 1);
    localparam logic [CHIP_W-1:0] CHIP_PRE  = CHIP_W'(SPREAD - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t              state;
    logic [SPREAD-1:0]   code;
    logic [DATA_W-1:0]   data_q;
    logic                mode_q;
    logic [CHIP_W-1:0]   chip_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                lfsr_out;
    logic                lfsr_en;
    logic                chip_xfer;
    logic                code_chip;

    assign chip_xfer = o_valid && i_ready;
    // LFSR runs through code capture, then only on accepted long-code chips.
    assign lfsr_en   = (state == S_LOAD) || (chip_xfer && (mode_q == MODE_LONG));

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (i_restart),
        .i_en      (lfsr_en),
        .o_data    (lfsr_out)
    );

    assign code_chip = (mode_q == MODE_LONG) ? lfsr_out : code[chip_cnt];
    assign o_data    = data_q[bit_cnt] ^ code_chip;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_LOAD;
            code     <= '0;
            data_q   <= '0;
            mode_q   <= MODE_SHORT;
            chip_cnt <= '0;
            bit_cnt  <= '0;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
        end else if (i_restart) begin
            state    <= S_LOAD;
            chip_cnt <= '0;
            bit_cnt  <= '0;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    // chip_cnt doubles as the capture index while loading
                    code[chip_cnt] <= lfsr_out;
                    if (chip_cnt == CHIP_LAST) begin
                        chip_cnt <= '0;
                        o_ready  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        chip_cnt <= chip_cnt + CHIP_W'(1);
                    end
                end
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        data_q   <= i_data;
                        mode_q   <= i_mode;
                        chip_cnt <= '0;
                        bit_cnt  <= '0;
                        o_ready  <= 1'b0;
                        o_valid  <= 1'b1;
                        o_last   <= 1'b0;
                        state    <= S_SPREAD;
                    end
                end
                S_SPREAD: begin
                    if (i_ready) begin
                        if (o_last) begin
                            chip_cnt <= '0;
                            bit_cnt  <= '0;
                            o_valid  <= 1'b0;
                            o_last   <= 1'b0;
                            o_ready  <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            if (chip_cnt == CHIP_LAST) begin
                                chip_cnt <= '0;
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                            end else begin
                                chip_cnt <= chip_cnt + CHIP_W'(1);
                            end
                            // Registered look-ahead: flag the chip about to be presented.
                            o_last <= (bit_cnt == BIT_LAST) && (chip_cnt == CHIP_PRE);
                        end
                    end
                end
                default: begin
                    state   <= S_LOAD;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spread_ch.sv
// Scoreboard bench for spread_ch at SPREAD=8, DATA_W=4.
module tb_spread_ch;

    localparam int unsigned SP   = 8;
    localparam int unsigned DW   = 4;
    localparam int unsigned WCH  = SP * DW;
    localparam logic [6:0]  POLY = 7'h03;
    localparam logic [6:0]  SEED = 7'h01;

    logic       clk;
    logic       i_reset;
    logic       i_restart;
    logic       i_mode;
    logic [3:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;

    int         n_cmp;
    int         n_err;
    int         hs_cnt;
    int         lpos;
    logic       seq [0:511];
    logic [7:0] code_ref;
    logic [1:0] exp_q [$];

    spread_ch #(
        .SPREAD (SP),
        .DATA_W (DW),
        .LFSR_W (7),
        .POLY   (POLY),
        .SEED   (SEED)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_restart (i_restart),
        .i_mode    (i_mode),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {last, chip} for the first nchips chips of a word.
    task automatic push_word(input logic [3:0] d, input logic m, input int nchips);
        for (int k = 0; k < nchips; k++) begin
            int   b;
            int   c;
            logic cb;
            b  = k / SP;
            c  = k % SP;
            cb = m ? seq[lpos + k] : code_ref[c];
            exp_q.push_back({(k == WCH - 1), d[b] ^ cb});
        end
        if (m) lpos += nchips;
    endtask

    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_chip", 32'd1, 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("chip", {30'd0, o_last, o_data}, {30'd0, e});
            end
        end
    end

    // Cycles from now until o_ready is seen high after an edge.
    task automatic ready_latency(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            n++;
            if (i_restart) i_restart = 1'b0;
            if (o_ready) break;
        end
    endtask

    task automatic send_word(input logic [3:0] d, input logic m, input int nchips);
        int i;
        @(negedge clk);
        for (i = 0; i < 200 && !o_ready; i++) @(negedge clk);
        if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
        push_word(d, m, nchips);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 200 && hs_cnt != target; i++) begin
            @(posedge clk); #1;
        end
        chk("hs_reach", hs_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   base;
        logic hd, hv, hl;

        n_cmp = 0; n_err = 0; hs_cnt = 0; lpos = SP;
        code_ref = 8'h81;
        begin
            logic [6:0] st;
            st = SEED;
            for (int i = 0; i < 512; i++) begin
                seq[i] = st[0];
                st = {^(st & POLY), st[6:1]};
            end
        end

        i_reset = 1'b1; i_restart = 1'b0; i_mode = 1'b0;
        i_data = '0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last",  o_last,  0);
        chk("rst_data",  o_data,  0);
        i_reset = 1'b0;
        ready_latency(n);
        chk("ready_lat", n, SP);

        // Mode 0, unstalled, then o_ready one cycle after the last handshake.
        send_word(4'b0010, 1'b0, WCH);
        wait_drain();
        @(posedge clk); #1;
        chk("ready_after_last", o_ready, 1);
        chk("valid_after_last", o_valid, 0);

        // Same word with a 3-cycle stall at chip 5.
        send_word(4'b0010, 1'b0, WCH);
        base = hs_cnt;
        wait_hs(base + 5);
        i_ready = 1'b0;
        hd = o_data; hv = o_valid; hl = o_last;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_data",  o_data,  hd);
            chk("stall_valid", o_valid, hv);
            chk("stall_last",  o_last,  hl);
        end
        i_ready = 1'b1;
        wait_drain();

        // Long code: data 0 shows raw LFSR, then a continuing word with input churn.
        send_word(4'b0000, 1'b1, WCH);
        wait_drain();
        send_word(4'b1010, 1'b1, WCH);
        i_mode = 1'b0;
        i_data = 4'b0101;
        wait_drain();

        // Restart at chip 10.
        send_word(4'b0101, 1'b0, 11);
        base = hs_cnt;
        wait_hs(base + 10);
        i_restart = 1'b1;
        ready_latency(n);
        chk("restart_ready_lat", n, SP + 1);
        chk("restart_drain", exp_q.size(), 0);
        lpos = SP;
        send_word(4'b1001, 1'b0, WCH);
        wait_drain();
        send_word(4'b0110, 1'b1, WCH);
        wait_drain();

        // Asynchronous reset mid-word.
        send_word(4'b1111, 1'b0, 3);
        base = hs_cnt;
        wait_hs(base + 3);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_last",  o_last,  0);
        chk("arst_ready", o_ready, 0);
        chk("arst_data",  o_data,  0);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        lpos = SP;
        ready_latency(n);
        chk("arst_ready_lat", n, SP);
        send_word(4'b0011, 1'b0, WCH);
        wait_drain();
        send_word(4'b1100, 1'b1, WCH);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
